// File: rtl/sequencer_pkg.sv
// Shared types for the step-sequencer blocks: note encoding, editor FSM
// states and the index of each front-panel button.
package sequencer_pkg;

  localparam int NOTE_W = 4;
  typedef logic [NOTE_W-1:0] note_t;
  localparam note_t NOTE_REST = '0;

  typedef enum logic {
    IDLE,
    CLEAR
  } editor_state_e;

  typedef enum int unsigned {
    BTN_CLEAR = 0,
    BTN_NEXT  = 1,
    BTN_PREV  = 2,
    BTN_UP    = 3,
    BTN_DOWN  = 4
  } btn_idx_e;

  localparam int NUM_BTN = 5;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus counting debouncer for one raw push button;
// emits a single-cycle press pulse on each debounced rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pattern_editor.sv
// Five-button step-pattern editor: moves a cursor over NUM_BEATS pitch
// nibbles, bumps the note under it, and sweeps the whole pattern on clear.
module pattern_editor
  import sequencer_pkg::*;
#(
  parameter int CLK_FREQ    = 12_000_000,
  parameter int NUM_BEATS   = 16,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         btn_next,
  input  logic                         btn_prev,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_clear,
  output logic [NUM_BEATS*NOTE_W-1:0]  beats,
  output logic [$clog2(NUM_BEATS)-1:0] cursor,
  output logic                         busy
);

  localparam int DEBOUNCE_CYCLES = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int CUR_W           = $clog2(NUM_BEATS);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw[BTN_CLEAR] = btn_clear;
  assign btn_raw[BTN_NEXT]  = btn_next;
  assign btn_raw[BTN_PREV]  = btn_prev;
  assign btn_raw[BTN_UP]    = btn_up;
  assign btn_raw[BTN_DOWN]  = btn_down;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[g]),
      .press_o(press[g])
    );
  end

  editor_state_e               state_q;
  logic [NUM_BEATS*NOTE_W-1:0] beats_q;
  logic [CUR_W-1:0]            cursor_q;
  logic [CUR_W-1:0]            sweep_idx_q;
  logic                        busy_q;
  note_t                       cur_note;

  assign cur_note = beats_q[int'(cursor_q)*NOTE_W +: NOTE_W];

  // Press pulses are acted on only in IDLE, so anything arriving mid-sweep is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      cursor_q    <= '0;
      sweep_idx_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press[BTN_CLEAR]) begin
            state_q     <= CLEAR;
            busy_q      <= 1'b1;
            sweep_idx_q <= '0;
          end else if (press[BTN_NEXT]) begin
            cursor_q <= cursor_q + CUR_W'(1);
          end else if (press[BTN_PREV]) begin
            cursor_q <= cursor_q - CUR_W'(1);
          end else if (press[BTN_UP]) begin
            beats_q[int'(cursor_q)*NOTE_W +: NOTE_W] <= cur_note + note_t'(1);
          end else if (press[BTN_DOWN]) begin
            beats_q[int'(cursor_q)*NOTE_W +: NOTE_W] <= cur_note - note_t'(1);
          end
        end
        CLEAR: begin
          beats_q[int'(sweep_idx_q)*NOTE_W +: NOTE_W] <= NOTE_REST;
          if (sweep_idx_q == CUR_W'(NUM_BEATS - 1)) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cursor_q    <= '0;
            sweep_idx_q <= '0;
          end else begin
            sweep_idx_q <= sweep_idx_q + CUR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign beats  = beats_q;
  assign cursor = cursor_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_pattern_editor.sv
// Scoreboard bench for pattern_editor: stimulus pushes expected snapshots
// stamped with the cycle they must appear; a monitor pops and compares.
module tb_pattern_editor;

  localparam int NB    = 16;
  localparam int LAT   = 7;   // button edge to visible action, in clock edges
  localparam int M_CLR = 1, M_NEXT = 2, M_PREV = 4, M_UP = 8, M_DOWN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_next = 1'b0, btn_prev = 1'b0, btn_up = 1'b0;
  logic        btn_down = 1'b0, btn_clear = 1'b0;
  logic [63:0] beats;
  logic [3:0]  cursor;
  logic        busy;

  pattern_editor #(
    .CLK_FREQ   (4000),
    .NUM_BEATS  (NB),
    .DEBOUNCE_MS(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .btn_prev (btn_prev),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_clear(btn_clear),
    .beats    (beats),
    .cursor   (cursor),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    logic [63:0] beats;
    int          cursor;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: one integer note per step plus a cursor position.
  int notes[NB];
  int m_cursor;
  int m_clr_p;

  function automatic logic [63:0] pack_notes();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i*4 +: 4] = notes[i][3:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int stamp, input logic b);
    exp_t e;
    e.stamp  = stamp;
    e.beats  = pack_notes();
    e.cursor = m_cursor;
    e.busy   = b;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) notes[i] = 0;
    m_cursor = 0;
    m_clr_p  = -1000;
  endtask

  // Event whose action lands on edge p; dropped while a sweep owns the editor.
  task automatic model_event(input int mask, input int p);
    if (mask == 0) return;
    if (p > m_clr_p && p <= m_clr_p + NB) return;
    push(p - 1, 1'b0);
    if ((mask & M_CLR) != 0) begin
      push(p, 1'b1);
      for (int k = 1; k <= NB; k++) begin
        notes[k-1] = 0;
        if (k == NB) m_cursor = 0;
        push(p + k, k < NB);
      end
      m_clr_p = p;
    end else if ((mask & M_NEXT) != 0) begin
      m_cursor = (m_cursor + 1) % NB;
      push(p, 1'b0);
    end else if ((mask & M_PREV) != 0) begin
      m_cursor = (m_cursor + NB - 1) % NB;
      push(p, 1'b0);
    end else if ((mask & M_UP) != 0) begin
      notes[m_cursor] = (notes[m_cursor] + 1) % 16;
      push(p, 1'b0);
    end else begin
      notes[m_cursor] = (notes[m_cursor] + 15) % 16;
      push(p, 1'b0);
    end
  endtask

  task automatic set_btns(input int mask);
    btn_clear = mask[0];
    btn_next  = mask[1];
    btn_prev  = mask[2];
    btn_up    = mask[3];
    btn_down  = mask[4];
  endtask

  task automatic press(input int mask);
    @(negedge clk);
    set_btns(mask);
    model_event(mask, cyc + LAT);
    repeat (10) @(negedge clk);
    set_btns(0);
    repeat (10) @(negedge clk);
    if ((mask & M_CLR) != 0) repeat (12) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
          e = sb.pop_front();
          check("beats",  beats,       e.beats);
          check("cursor", 64'(cursor), 64'(e.cursor));
          check("busy",   64'(busy),   64'(e.busy));
        end
      end
    end
  end

  initial begin : stimulus
    int mask;
    int guard;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset_beats",  beats,       64'h0);
    check("reset_cursor", 64'(cursor), 64'h0);
    check("reset_busy",   64'(busy),   64'h0);
    rst = 1'b0;

    repeat (3) press(M_UP);
    check("three_ups", beats, 64'h3);
    check("three_ups_cursor", 64'(cursor), 64'h0);

    press(M_PREV);
    check("prev_wrap", 64'(cursor), 64'd15);
    press(M_NEXT);
    check("next_wrap", 64'(cursor), 64'd0);
    press(M_PREV);
    press(M_DOWN);
    check("down_wrap", beats, 64'hF000_0000_0000_0003);
    press(M_NEXT);

    // Bouncing up button: only the final steady level may count.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn_up = (i % 2 == 0);
      @(negedge clk);
    end
    btn_up = 1'b1;
    model_event(M_UP, cyc + LAT);
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_once", beats, 64'hF000_0000_0000_0004);

    press(M_NEXT | M_UP);
    check("prio_cursor", 64'(cursor), 64'd1);
    check("prio_beats",  beats, 64'hF000_0000_0000_0004);

    press(M_CLR);
    for (int i = 0; i < NB; i++) begin
      if (i < 8) repeat (i) press(M_UP);
      else       repeat (NB - i) press(M_DOWN);
      if (i < NB - 1) press(M_NEXT);
    end
    repeat (8) press(M_PREV);
    check("build_beats",  beats,       64'hFEDC_BA98_7654_3210);
    check("build_cursor", 64'(cursor), 64'd7);

    // Clear sweep with an up press landing mid-sweep.
    @(negedge clk);
    btn_clear = 1'b1;
    model_event(M_CLR, cyc + LAT);
    repeat (8) @(negedge clk);
    btn_up = 1'b1;
    model_event(M_UP, cyc + LAT);
    repeat (2) @(negedge clk);
    btn_clear = 1'b0;
    repeat (8) @(negedge clk);
    btn_up = 1'b0;
    repeat (30) @(negedge clk);
    check("sweep_beats",  beats,       64'h0);
    check("sweep_cursor", 64'(cursor), 64'h0);

    for (int n = 0; n < 40; n++) begin
      mask = 1 << $urandom_range(1, 4);
      case ($urandom_range(0, 9))
        0:       mask = M_CLR;
        1:       mask = mask | (1 << $urandom_range(1, 4));
        default: ;
      endcase
      press(mask);
    end

    // Reset in the middle of a sweep over a non-trivial pattern.
    guard = 0;
    while (m_cursor != 10 && guard < NB) begin
      press(M_NEXT);
      guard++;
    end
    press(M_UP);
    @(negedge clk);
    btn_clear = 1'b1;
    model_event(M_CLR, cyc + LAT);
    repeat (LAT + 5) @(posedge clk);
    #2;
    check("abort_busy_pre", 64'(busy), 64'h1);
    rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    check("abort_beats",  beats,       64'h0);
    check("abort_cursor", 64'(cursor), 64'h0);
    check("abort_busy",   64'(busy),   64'h0);
    btn_clear = 1'b0;
    btn_up    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_event(M_UP, cyc + LAT);
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check("held_through_reset", beats, 64'h1);

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected snapshots never compared, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
